// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory behind the core's load/store valid/ready port.
// Programmable wait states between accept and access, single-cycle response strobe.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  // state  | meaning
  // S_IDLE | ready; a zero-wait request is served on its accept edge
  // S_WAIT | request latched, counter running down the wait states
  // S_RESP | rsp_valid high for one cycle with registered data/error
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int         DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       accept, access;

  logic        lat_we;
  logic [31:0] lat_addr;
  logic [2:0]  lat_funct3;
  logic [31:0] lat_wdata;

  logic        acc_we;
  logic [31:0] acc_addr;
  logic [2:0]  acc_funct3;
  logic [31:0] acc_wdata;
  logic        acc_err;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            lane;
  logic [3:0]            byte_en;
  logic [31:0]           wr_data;
  logic [31:0]           rd_word;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [31:0]           ld_data;
  logic                  mem_wr;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    access    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            access    = 1'b1;
            state_nxt = S_RESP;
          end else begin
            cnt_nxt   = CNT_INIT;
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          access    = 1'b1;
          state_nxt = S_RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_we     <= 1'b0;
      lat_addr   <= 32'd0;
      lat_funct3 <= 3'd0;
      lat_wdata  <= 32'd0;
    end else if (accept) begin
      lat_we     <= req_we;
      lat_addr   <= req_addr;
      lat_funct3 <= req_funct3;
      lat_wdata  <= req_wdata;
    end
  end

  // With no wait states the access happens on the accept edge, before the latch holds the request.
  assign acc_we     = (state == S_IDLE) ? req_we     : lat_we;
  assign acc_addr   = (state == S_IDLE) ? req_addr   : lat_addr;
  assign acc_funct3 = (state == S_IDLE) ? req_funct3 : lat_funct3;
  assign acc_wdata  = (state == S_IDLE) ? req_wdata  : lat_wdata;

  always_comb begin
    acc_err = 1'b0;
    case (acc_funct3)
      3'b011, 3'b110, 3'b111: acc_err = 1'b1;
      3'b100, 3'b101:         if (acc_we) acc_err = 1'b1;
      default:                ;
    endcase
    if (acc_funct3[1:0] == 2'b01 && acc_addr[0])            acc_err = 1'b1;
    if (acc_funct3 == 3'b010 && acc_addr[1:0] != 2'b00)     acc_err = 1'b1;
    if (|acc_addr[31:ADDR_WIDTH+2])                          acc_err = 1'b1;
  end

  assign word_idx = acc_addr[ADDR_WIDTH+1:2];
  assign lane     = acc_addr[1:0];

  always_comb begin
    byte_en = 4'b0000;
    wr_data = acc_wdata;
    case (acc_funct3[1:0])
      2'b00: begin
        byte_en = 4'b0001 << lane;
        wr_data = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{acc_wdata[15:0]}};
      end
      2'b10:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  // Gating on rst keeps a zero-wait request from writing while reset is held.
  assign mem_wr = access & acc_we & ~acc_err & rst;

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) mem[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  assign rd_word = mem[word_idx];

  always_comb begin
    case (lane)
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    ld_data = 32'd0;
    if (!acc_err && !acc_we) begin
      case (acc_funct3)
        3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
        3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
        3'b010:  ld_data = rd_word;
        3'b100:  ld_data = {24'd0, rd_byte};
        3'b101:  ld_data = {16'd0, rd_half};
        default: ld_data = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (access) begin
      rsp_rdata <= ld_data;
      rsp_err   <= acc_err;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four instances (1, 3, 2 and 0 wait states) checked every cycle
// against a byte-array / elapsed-edge reference model, plus directed literal cases.
module tb_dmem_responder;
  localparam int N  = 4;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid  [N];
  logic        req_ready  [N];
  logic        req_we     [N];
  logic [31:0] req_addr   [N];
  logic [2:0]  req_funct3 [N];
  logic [31:0] req_wdata  [N];
  logic        rsp_valid  [N];
  logic [31:0] rsp_rdata  [N];
  logic        rsp_err    [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    dmem_responder #(
      .ADDR_WIDTH (AW),
      .WAIT_CYCLES((g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 2 : 0)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_funct3(req_funct3[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  function automatic int wc_of(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      2:       return 2;
      default: return 0;
    endcase
  endfunction

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h t=%0t", nm, i, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm, input int i);
    total++;
    bad++;
    $display("FAIL %s[%0d] timed out t=%0t", nm, i, $time);
  endtask

  // reference model: byte memory, and edges elapsed since accept (-1 = idle)
  logic [7:0]  mmem    [N][4096];
  bit          mknown  [N][4096];
  int          m_since [N];
  bit          p_we    [N];
  logic [31:0] p_addr  [N];
  logic [2:0]  p_f3    [N];
  logic [31:0] p_wdata [N];
  bit          m_err   [N];
  logic [31:0] m_rdata [N];
  bit          m_rknown[N];
  int          rsp_cnt [N];

  function automatic bit model_err(input bit we, input logic [31:0] a, input logic [2:0] f3);
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    if (we && (f3 == 4 || f3 == 5))    return 1'b1;
    if ((f3 == 1 || f3 == 5) && (a % 2) != 0) return 1'b1;
    if (f3 == 2 && (a % 4) != 0)       return 1'b1;
    if (longint'(a) >= 4 * (longint'(1) << AW)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  task automatic model_access(input int i);
    int nb, a;
    logic [31:0] v;
    bit kn;
    nb = nbytes(p_f3[i]);
    a  = int'(p_addr[i] % 4096);
    if (m_err[i]) begin
      m_rdata[i] = 32'd0;  m_rknown[i] = 1'b1;
    end else if (p_we[i]) begin
      for (int b = 0; b < nb; b++) begin
        mmem[i][a+b]   = p_wdata[i][8*b +: 8];
        mknown[i][a+b] = 1'b1;
      end
      m_rdata[i] = 32'd0;  m_rknown[i] = 1'b1;
    end else begin
      v = 32'd0;  kn = 1'b1;
      for (int b = 0; b < nb; b++) begin
        v  = v | (32'(mmem[i][a+b]) << (8*b));
        kn = kn & mknown[i][a+b];
      end
      if (p_f3[i] == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
      if (p_f3[i] == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
      m_rdata[i] = v;  m_rknown[i] = kn;
    end
  endtask

  task automatic model_step(input int i);
    int wc;
    wc = wc_of(i);
    if (!rst) begin
      m_since[i] = -1;
    end else if (m_since[i] >= 0) begin
      m_since[i]++;
      if (m_since[i] == wc + 1)  m_since[i] = -1;
      else if (m_since[i] == wc) model_access(i);
    end else if (req_valid[i]) begin
      m_since[i] = 0;
      p_we[i] = req_we[i];  p_addr[i] = req_addr[i];
      p_f3[i] = req_funct3[i];  p_wdata[i] = req_wdata[i];
      m_err[i] = model_err(req_we[i], req_addr[i], req_funct3[i]);
      if (wc == 0) model_access(i);
    end
  endtask

  always @(posedge clk) for (int i = 0; i < N; i++) model_step(i);

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst) begin
        chk("rst_ready", i, 32'(req_ready[i]), 32'd1);
        chk("rst_valid", i, 32'(rsp_valid[i]), 32'd0);
        chk("rst_rdata", i, rsp_rdata[i], 32'd0);
        chk("rst_err",   i, 32'(rsp_err[i]), 32'd0);
      end else begin
        chk("ready", i, 32'(req_ready[i]), 32'(m_since[i] < 0));
        chk("valid", i, 32'(rsp_valid[i]), 32'(m_since[i] == wc_of(i)));
        if (m_since[i] == wc_of(i)) begin
          chk("err", i, 32'(rsp_err[i]), 32'(m_err[i]));
          if (m_rknown[i]) chk("rdata", i, rsp_rdata[i], m_rdata[i]);
        end
      end
    end
  end

  always @(negedge clk) for (int i = 0; i < N; i++) if (rsp_valid[i]) rsp_cnt[i]++;

  // One request: present, wait for acceptance, measure latency, return the response.
  task automatic do_req(input int i, input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output bit er);
    int n, lat;
    rd = 32'd0;  er = 1'b0;
    @(negedge clk); #1;
    req_we[i] = we;  req_funct3[i] = f3;  req_addr[i] = a;  req_wdata[i] = wd;
    req_valid[i] = 1'b1;
    n = 0;
    while (!req_ready[i] && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    if (!req_ready[i]) begin
      timeout("accept", i);
      req_valid[i] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid[i] && lat < 40);
    if (!rsp_valid[i]) begin
      timeout("response", i);
      return;
    end
    chk("latency", i, 32'(lat), 32'(wc_of(i) + 1));
    rd = rsp_rdata[i];
    er = rsp_err[i];
    @(negedge clk);
    chk("one_cycle", i, 32'(rsp_valid[i]), 32'd0);
  endtask

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          er;
  } dreq_t;

  dreq_t tab[$];

  function automatic dreq_t mk(input bit we, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] rd, input bit er);
    dreq_t d;
    d.we = we;  d.f3 = f3;  d.a = a;  d.wd = wd;  d.rd = rd;  d.er = er;
    return d;
  endfunction

  task automatic run_directed(input int i);
    logic [31:0] rd;
    bit er;
    foreach (tab[k]) begin
      do_req(i, tab[k].we, tab[k].f3, tab[k].a, tab[k].wd, rd, er);
      chk("dir_rdata", i, rd, tab[k].rd);
      chk("dir_err",   i, 32'(er), 32'(tab[k].er));
      chk("dir_model", i, m_rdata[i], tab[k].rd);
    end
  endtask

  task automatic rand_run(input int i);
    logic [31:0] rd, a;
    logic [2:0]  f3;
    bit er, we;
    int r;
    for (int n = 0; n < 120; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      we = 1'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 19));
      case (r % 5)
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = 3'b100;
        default: f3 = 3'b101;
      endcase
      if (r == 17) f3 = 3'b011;
      if (r == 18) f3 = 3'b110;
      if (r == 19) f3 = 3'b111;
      a = 32'h100 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = a & ~32'(nbytes(f3) - 1);
      if ($urandom_range(0, 15) == 0) a = a | (32'd1 << $urandom_range(12, 31));
      do_req(i, we, f3, a, $urandom, rd, er);
    end
  endtask

  logic [31:0] hw  [3];
  logic [31:0] cap [3];
  longint      t_acc[3];

  initial begin
    logic [31:0] rd;
    bit er;
    int got, lowc, n, c0;

    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b0;  req_we[i] = 1'b0;  req_addr[i] = 32'd0;
      req_funct3[i] = 3'd0; req_wdata[i] = 32'd0;
      m_since[i] = -1;
    end
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;

    tab.push_back(mk(1, 3'b010, 32'h010, 32'hDEADBEEF, 32'h0,        0));
    tab.push_back(mk(0, 3'b010, 32'h010, 32'h0,        32'hDEADBEEF, 0));
    tab.push_back(mk(0, 3'b000, 32'h013, 32'h0,        32'hFFFFFFDE, 0));
    tab.push_back(mk(0, 3'b100, 32'h013, 32'h0,        32'h000000DE, 0));
    tab.push_back(mk(0, 3'b001, 32'h012, 32'h0,        32'hFFFFDEAD, 0));
    tab.push_back(mk(0, 3'b101, 32'h012, 32'h0,        32'h0000DEAD, 0));
    tab.push_back(mk(0, 3'b000, 32'h010, 32'h0,        32'hFFFFFFEF, 0));
    tab.push_back(mk(1, 3'b000, 32'h011, 32'h12345655, 32'h0,        0));
    tab.push_back(mk(0, 3'b010, 32'h010, 32'h0,        32'hDEAD55EF, 0));
    tab.push_back(mk(1, 3'b001, 32'h012, 32'h0000ABCD, 32'h0,        0));
    tab.push_back(mk(0, 3'b010, 32'h010, 32'h0,        32'hABCD55EF, 0));
    tab.push_back(mk(0, 3'b010, 32'h012, 32'h0,        32'h0,        1));
    tab.push_back(mk(1, 3'b001, 32'h011, 32'h0000FFFF, 32'h0,        1));
    tab.push_back(mk(0, 3'b011, 32'h010, 32'h0,        32'h0,        1));
    tab.push_back(mk(1, 3'b100, 32'h010, 32'h00000077, 32'h0,        1));
    tab.push_back(mk(0, 3'b010, 32'h1000, 32'h0,       32'h0,        1));
    tab.push_back(mk(0, 3'b010, 32'h010, 32'h0,        32'hABCD55EF, 0));

    fork
      run_directed(0);
      run_directed(3);
    join

    // back-to-back loads with req_valid held high, 3 wait states
    hw[0] = 32'hA5A50001;  hw[1] = 32'h5A5A0002;  hw[2] = 32'hC3C30003;
    for (int k = 0; k < 3; k++) do_req(1, 1'b1, 3'b010, 32'h40 + 32'(4*k), hw[k], rd, er);
    @(negedge clk); #1;
    req_we[1] = 1'b0;  req_funct3[1] = 3'b010;  req_addr[1] = 32'h40;  req_valid[1] = 1'b1;
    got = 0;
    for (int k = 0; k < 3; k++) begin
      chk("hold_ready", 1, 32'(req_ready[1]), 32'd1);
      @(posedge clk);
      t_acc[k] = longint'($time);
      #1;
      if (k < 2) req_addr[1] = 32'h40 + 32'(4*(k+1));
      else       req_valid[1] = 1'b0;
      lowc = 0;
      n = 0;
      forever begin
        @(negedge clk);
        if (rsp_valid[1]) begin
          cap[k] = rsp_rdata[1];
          got++;
        end
        if (req_ready[1] || n > 20) break;
        lowc++;
        n++;
      end
      chk("hold_lowc", 1, 32'(lowc), 32'd4);
      if (k > 0) chk("hold_spacing", 1, 32'(t_acc[k] - t_acc[k-1]), 32'd50);
    end
    chk("hold_pulses", 1, 32'(got), 32'd3);
    for (int k = 0; k < 3; k++) chk("hold_data", 1, cap[k], hw[k]);

    fork
      rand_run(0);
      rand_run(1);
      rand_run(2);
      rand_run(3);
    join

    // reset dropped while the second store waits
    do_req(2, 1'b1, 3'b010, 32'h020, 32'h11111111, rd, er);
    chk("rst_first_err", 2, 32'(er), 32'd0);
    c0 = rsp_cnt[2];
    @(negedge clk); #1;
    req_we[2] = 1'b1;  req_funct3[2] = 3'b010;  req_addr[2] = 32'h020;
    req_wdata[2] = 32'h22222222;  req_valid[2] = 1'b1;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(negedge clk);
    chk("rst_in_wait", 2, 32'(req_ready[2]), 32'd0);
    #1 rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_noresp", 2, 32'(rsp_valid[2]), 32'd0);
    end
    #1 rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_noresp", 2, 32'(rsp_valid[2]), 32'd0);
      chk("post_ready",  2, 32'(req_ready[2]), 32'd1);
    end
    chk("rst_pulses", 2, 32'(rsp_cnt[2]), 32'(c0));
    do_req(2, 1'b0, 3'b010, 32'h020, 32'h0, rd, er);
    chk("rst_keep", 2, rd, 32'h11111111);
    chk("rst_keep_err", 2, 32'(er), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
